// File: rtl/time_counter_chain.sv
// Cascaded wrap-around time counter with per-stage bounds.
// Single-cycle ripple carry/borrow, presets and wrap flags.
module time_counter_chain #(
  parameter int BUS_WIDTH = 6,
  parameter int STAGES    = 3,
  parameter int SEL_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           tick,
  input  logic                           dir,
  input  logic [STAGES*BUS_WIDTH-1:0]    min_bus,
  input  logic [STAGES*BUS_WIDTH-1:0]    max_bus,
  input  logic                           set_en,
  input  logic [SEL_WIDTH-1:0]           set_sel,
  input  logic [BUS_WIDTH-1:0]           set_value,
  output logic [STAGES*BUS_WIDTH-1:0]    data_bus,
  output logic [STAGES-1:0]              stage_wrap,
  output logic                           carry_out
);

  typedef logic [STAGES-1:0][BUS_WIDTH-1:0] fields_t;

  fields_t           val_q, val_d;
  fields_t           lo, hi;
  logic [STAGES-1:0] wrap_q, wrap_d;
  logic [STAGES-1:0] term;
  logic              step;
  logic              run;

  assign lo = min_bus;
  assign hi = max_bus;
  assign step = enable & tick & ~set_en;

  // run ripples upward: a stage moves only if all lower stages sit at their
  // terminal value in the current direction, so the whole chain settles
  // on one edge.
  always_comb begin
    val_d  = val_q;
    wrap_d = '0;
    term   = '0;
    run    = step;
    for (int k = 0; k < STAGES; k++) begin
      term[k] = dir ? (val_q[k] <= lo[k]) : (val_q[k] >= hi[k]);
      if (run) begin
        if (term[k]) begin
          val_d[k]  = dir ? hi[k] : lo[k];
          wrap_d[k] = 1'b1;
        end else if (dir) begin
          val_d[k] = val_q[k] - BUS_WIDTH'(1);
        end else begin
          val_d[k] = val_q[k] + BUS_WIDTH'(1);
        end
      end
      run = run & term[k];
      if (set_en && set_sel == SEL_WIDTH'(k)) begin
        if (set_value > hi[k]) begin
          val_d[k] = hi[k];
        end else if (set_value < lo[k]) begin
          val_d[k] = lo[k];
        end else begin
          val_d[k] = set_value;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      val_q  <= lo;
      wrap_q <= '0;
    end else begin
      val_q  <= val_d;
      wrap_q <= wrap_d;
    end
  end

  assign data_bus   = val_q;
  assign stage_wrap = wrap_q;
  assign carry_out  = wrap_q[STAGES-1];

endmodule

// File: tb/tb_time_counter_chain.sv
// Directed bench for time_counter_chain (3 stages, 6-bit fields).
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_time_counter_chain;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        tick;
  logic        dir;
  logic [17:0] min_bus;
  logic [17:0] max_bus;
  logic        set_en;
  logic [1:0]  set_sel;
  logic [5:0]  set_value;
  logic [17:0] data_bus;
  logic [2:0]  stage_wrap;
  logic        carry_out;

  int checks;
  int failures;

  time_counter_chain #(
    .BUS_WIDTH(6),
    .STAGES(3),
    .SEL_WIDTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .tick(tick),
    .dir(dir),
    .min_bus(min_bus),
    .max_bus(max_bus),
    .set_en(set_en),
    .set_sel(set_sel),
    .set_value(set_value),
    .data_bus(data_bus),
    .stage_wrap(stage_wrap),
    .carry_out(carry_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        en;
    logic        tk;
    logic        dr;
    logic        se;
    logic [1:0]  ss;
    logic [5:0]  sv;
    logic [17:0] ed;
    logic [2:0]  ew;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [17:0] dv(int h, int m, int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic vec_t mk(string nm, logic en, logic tk, logic dr,
                              logic se, logic [1:0] ss, logic [5:0] sv,
                              logic [17:0] ed, logic [2:0] ew);
    vec_t v;
    v.nm = nm; v.en = en; v.tk = tk; v.dr = dr;
    v.se = se; v.ss = ss; v.sv = sv; v.ed = ed; v.ew = ew;
    return v;
  endfunction

  task automatic check(string nm, logic [17:0] ed, logic [2:0] ew);
    checks++;
    if (data_bus !== ed || stage_wrap !== ew || carry_out !== ew[2]) begin
      failures++;
      $display("FAIL %s: data=%0d/%0d/%0d wrap=%b carry=%b, want %0d/%0d/%0d wrap=%b carry=%b",
               nm, data_bus[17:12], data_bus[11:6], data_bus[5:0],
               stage_wrap, carry_out, ed[17:12], ed[11:6], ed[5:0],
               ew, ew[2]);
    end
  endtask

  task automatic apply(logic en, logic tk, logic dr, logic se,
                       logic [1:0] ss, logic [5:0] sv);
    @(negedge clock);
    enable = en; tick = tk; dir = dr;
    set_en = se; set_sel = ss; set_value = sv;
    @(posedge clock);
    #1;
  endtask

  task automatic preset(logic [1:0] ss, logic [5:0] sv);
    apply(1'b1, 1'b0, 1'b0, 1'b1, ss, sv);
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_async", {min_bus[17:12], min_bus[11:6], min_bus[5:0]}, 3'b000);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; enable = 1'b0; tick = 1'b0; dir = 1'b0;
    set_en = 1'b0; set_sel = 2'd0; set_value = 6'd0;
    min_bus = dv(0, 0, 0);
    max_bus = dv(23, 59, 59);
    #2;
    check("reset_state", dv(0, 0, 0), 3'b000);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 59; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check("up59", dv(0, 0, 59), 3'b000);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check("sec_wrap", dv(0, 1, 0), 3'b001);
    idle();
    check("sec_wrap_clear", dv(0, 1, 0), 3'b000);

    tbl[0]  = mk("set_s59",   1, 0, 0, 1, 2'd0, 6'd59, dv(0, 1, 59),    3'b000);
    tbl[1]  = mk("set_m59",   1, 0, 0, 1, 2'd1, 6'd59, dv(0, 59, 59),   3'b000);
    tbl[2]  = mk("set_h23",   1, 0, 0, 1, 2'd2, 6'd23, dv(23, 59, 59),  3'b000);
    tbl[3]  = mk("full_roll", 1, 1, 0, 0, 2'd0, 6'd0,  dv(0, 0, 0),     3'b111);
    tbl[4]  = mk("roll_clr",  1, 0, 0, 0, 2'd0, 6'd0,  dv(0, 0, 0),     3'b000);
    tbl[5]  = mk("full_borr", 1, 1, 1, 0, 2'd0, 6'd0,  dv(23, 59, 59),  3'b111);
    tbl[6]  = mk("down1",     1, 1, 1, 0, 2'd0, 6'd0,  dv(23, 59, 58),  3'b000);
    tbl[7]  = mk("set_h5",    1, 0, 0, 1, 2'd2, 6'd5,  dv(5, 59, 58),   3'b000);
    tbl[8]  = mk("clamp_h30", 1, 0, 0, 1, 2'd2, 6'd30, dv(23, 59, 58),  3'b000);
    tbl[9]  = mk("sel3",      1, 0, 0, 1, 2'd3, 6'd10, dv(23, 59, 58),  3'b000);
    tbl[10] = mk("set_tick",  1, 1, 0, 1, 2'd1, 6'd10, dv(23, 10, 58),  3'b000);
    tbl[11] = mk("sel3_tick", 1, 1, 0, 1, 2'd3, 6'd10, dv(23, 10, 58),  3'b000);
    tbl[12] = mk("set_noen",  0, 0, 0, 1, 2'd0, 6'd40, dv(23, 10, 40),  3'b000);
    tbl[13] = mk("up_again",  1, 1, 0, 0, 2'd0, 6'd0,  dv(23, 10, 41),  3'b000);
    tbl[14] = mk("dir_flip",  1, 1, 1, 0, 2'd0, 6'd0,  dv(23, 10, 40),  3'b000);
    tbl[15] = mk("set_m59b",  1, 0, 0, 1, 2'd1, 6'd59, dv(23, 59, 40),  3'b000);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].en, tbl[i].tk, tbl[i].dr, tbl[i].se, tbl[i].ss, tbl[i].sv);
      check(tbl[i].nm, tbl[i].ed, tbl[i].ew);
    end

    preset(2'd0, 6'd59);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
      check("en_low", dv(23, 59, 59), 3'b000);
    end

    preset(2'd2, 6'd12);
    preset(2'd1, 6'd34);
    preset(2'd0, 6'd56);
    check("pre_mid", dv(12, 34, 56), 3'b000);
    @(negedge clock);
    enable = 1'b1; tick = 1'b1; dir = 1'b0; set_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset", dv(0, 0, 0), 3'b000);
    @(posedge clock);
    #1;
    check("reset_hold", dv(0, 0, 0), 3'b000);
    tick = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    @(negedge clock);
    min_bus = dv(1, 0, 0);
    max_bus = dv(12, 59, 59);
    do_reset();
    preset(2'd2, 6'd0);
    check("clamp_lo", dv(1, 0, 0), 3'b000);
    preset(2'd2, 6'd12);
    preset(2'd1, 6'd59);
    preset(2'd0, 6'd59);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check("h12_up", dv(1, 0, 0), 3'b111);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
    check("h1_down", dv(12, 59, 59), 3'b111);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
    check("h12_down1", dv(12, 59, 58), 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_counter_chain.md
Name: time_counter_chain

Overview:
- Parametrised, cascaded wrap-around time counter: STAGES digit fields (e.g. sec/min/hour), each with its own run-time min/max bounds.
- Supports up/down counting, a single-cycle ripple carry/borrow through all stages, per-stage preset loading, and registered wrap flags.
- Sits between the 1 Hz tick generator and the display/alarm logic of the clock design.

Parameters:
- BUS_WIDTH, 6, width of each stage field.
- STAGES, 3, number of cascaded stages; stage 0 is least significant.
- SEL_WIDTH, 2, width of set_sel; must satisfy 2^SEL_WIDTH >= STAGES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run gate; tick is ignored while low.
- tick  input  1  one-cycle step request for stage 0.
- dir  input  1  0 = count up, 1 = count down; sampled with tick.
- min_bus  input  STAGES*BUS_WIDTH  per-stage lower bound; stage k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- max_bus  input  STAGES*BUS_WIDTH  per-stage upper bound, same packing; min <= max required.
- set_en  input  1  preset strobe.
- set_sel  input  SEL_WIDTH  stage index for the preset.
- set_value  input  BUS_WIDTH  preset value.
- data_bus  output  STAGES*BUS_WIDTH  current stage values, same packing, registered.
- stage_wrap  output  STAGES  per-stage wrap pulse, registered.
- carry_out  output  1  equals stage_wrap[STAGES-1]; signals full-chain rollover.

Behaviour:
- Reset (asynchronous, active-low):
  - Each stage loads its min_bus field.
  - stage_wrap and carry_out clear to 0.
  - Takes effect immediately, including mid-operation.
  - min_bus and max_bus must be stable while reset is low and must be treated as quasi-static during run.
- Step condition: step = enable & tick & ~set_en.
- Stage k advances when step is high and every stage below k is at its terminal value.
  - Terminal value is max when counting up, min when counting down.
  - The chain is combinational, so all affected stages update on the same edge. There is no one-cycle carry lag.
- Up-count per advancing stage:
  - value >= max: load min and set stage_wrap[k].
  - otherwise: value + 1, truncated to BUS_WIDTH.
- Down-count per advancing stage:
  - value <= min: load max and set stage_wrap[k].
  - otherwise: value - 1.
- Out-of-range values (above max when counting up, below min when counting down) recover through the wrap rule above and still raise the wrap flag.
- Latency: data_bus and stage_wrap update on the same rising edge that samples tick. Flags are high for exactly one cycle.
- stage_wrap clears on any cycle without a step.
- Preset (set_en high):
  - Stage set_sel loads clamp(set_value, min, max): values above max store max, values below min store min.
  - Other stages hold; no stage_wrap bits are set.
  - A tick arriving in the same cycle is dropped, not queued.
  - set_sel >= STAGES: no stage changes, tick still dropped.
  - set_en works regardless of enable.
- dir may change between ticks. The terminal test uses the dir value of the current cycle.
- When enable is low, all stages hold and stage_wrap is 0.

Test Plan:
- Setup for all scenarios: STAGES=3, BUS_WIDTH=6; min 0/0/0, max 59/59/23 (stages 0/1/2).
- Reset, then 59 ticks up -> data_bus = {0,0,59}; next tick -> {0,1,0}, stage_wrap = 3'b001 for one cycle.
- Preset stages to {23,59,59}, tick up -> {0,0,0} on the same edge, stage_wrap = 3'b111, carry_out = 1 for exactly one cycle, then 0.
- From {0,0,0}, dir=1, tick -> {23,59,59}, stage_wrap = 3'b111. Next tick -> {23,59,58}, stage_wrap = 0.
- Presets:
  - set_sel=2, set_value=30 -> hour = 23.
  - set_sel=3 -> no change.
  - set_en and tick in the same cycle -> only the preset applies and the seconds field is unchanged.
- enable=0 with 5 ticks -> data_bus unchanged, stage_wrap = 0.
- Assert reset low mid-count at {12,34,56} between clock edges -> outputs return to {0,0,0} immediately, before the next edge.
- Rerun with min=1, max=12 on stage 2 -> hour wraps 12 -> 1 when counting up and 1 -> 12 when counting down.
